// File: rtl/apb_regfile.sv
// apb_regfile: APB slave register bank with read-only protection, range errors and optional wait states
//
// Parameters:
//   DATA_W      register / data-bus width
//   NUM_REGS    number of registers (1..2^ADDR_W)
//   ADDR_W      paddr width; paddr is a register index
//   RO_MASK     bit i = 1 makes register i read-only (only reset writes it)
//   WAIT_CYCLES wait states per transfer (0..15), used only with APB_REGFILE_WAIT_EN
// Build option:
//   APB_REGFILE_WAIT_EN  when defined, every transfer inserts WAIT_CYCLES wait states
// Ports:
//   pclk, preset_n            clock, async active-low reset
//   psel, penable, pwrite     APB control
//   paddr, pwdata             register index and write data (captured at SETUP)
//   prdata, pready, pslverr   read data, transfer done, error (all zero unless pready)
module apb_regfile #(
    parameter int unsigned         DATA_W      = 8,
    parameter int unsigned         NUM_REGS    = 8,
    parameter int unsigned         ADDR_W      = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter int unsigned         WAIT_CYCLES = 2
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);
    localparam int unsigned IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e            state_q, state;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [IDX_W-1:0]  idx;
    logic              in_range, err;

    // SETUP is the bus cycle in which the master presents psel & !penable while we are
    // not mid-transfer; decoding it here lets ACCESS follow in the very next cycle.
    assign state    = state_q == ACCESS ? ACCESS : (psel && !penable) ? SETUP : IDLE;
    assign idx      = addr_q[IDX_W-1:0];
    // Extra bit keeps the compare exact when NUM_REGS == 2^ADDR_W.
    assign in_range = {1'b0, addr_q} < (ADDR_W+1)'(NUM_REGS);
    assign err      = !in_range || (write_q && RO_MASK[idx]);

`ifdef APB_REGFILE_WAIT_EN
    logic [3:0] wait_q;
    assign pready = state_q == ACCESS && wait_q == 4'd0;
`else
    assign pready = state_q == ACCESS;
`endif

    assign pslverr = pready && err;
    assign prdata  = (pready && !err && !write_q) ? mem_q[idx] : '0;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
`ifdef APB_REGFILE_WAIT_EN
            wait_q  <= 4'd0;
`endif
            for (int i = 0; i < int'(NUM_REGS); i++) mem_q[i] <= '0;
        end else begin
            case (state)
                SETUP: begin
                    state_q <= ACCESS;
                    addr_q  <= paddr;
                    write_q <= pwrite;
                    wdata_q <= pwdata;
`ifdef APB_REGFILE_WAIT_EN
                    wait_q  <= 4'(WAIT_CYCLES);
`endif
                end
                ACCESS: begin
                    if (pready) begin
                        state_q <= IDLE;
                        if (write_q && !err) mem_q[idx] <= wdata_q;
                    end
`ifdef APB_REGFILE_WAIT_EN
                    else wait_q <= wait_q - 4'd1;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_regfile.sv
// tb_apb_regfile: directed table-driven check of apb_regfile
module tb_apb_regfile;
`ifdef APB_REGFILE_WAIT_EN
    localparam int W = 3;
`else
    localparam int W = 0;
`endif

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        bit         exp_err;
    } vec_t;

    logic       pclk = 1'b0, preset_n = 1'b0, psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0] paddr = '0, pwdata = '0;
    logic [7:0] prdata;
    logic       pready, pslverr;
    int         n_cmp = 0, n_err = 0;
    vec_t       vq[$];

    apb_regfile #(.DATA_W(8), .NUM_REGS(8), .ADDR_W(8), .RO_MASK(8'h04), .WAIT_CYCLES(3)) dut (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit wr, input logic [7:0] a, d, r, input bit e);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.exp_rd = r; v.exp_err = e;
        vq.push_back(v);
    endtask

    // Called at posedge+1; returns at posedge+1 with the bus idle so a following call is back-to-back.
    task automatic xfer(input bit wr, input logic [7:0] a, d,
                        output logic [7:0] rd, output bit er, output int cyc);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        paddr = ~a; pwdata = ~d; pwrite = ~wr;
        cyc = 0;
        do begin
            @(negedge pclk);
            cyc++;
        end while (!pready && cyc < 40);
        rd = prdata; er = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        bit         er;
        int         cyc;
        add(1, 3, 8'hA5, 8'h00, 0);
        add(0, 3, 8'h00, 8'hA5, 0);
        add(0, 0, 8'h00, 8'h00, 0);
        add(0, 7, 8'h00, 8'h00, 0);
        for (int i = 0; i < 8; i++) add(1, 8'(i), 8'(8'h10 + i), 8'h00, i == 2);
        for (int i = 0; i < 8; i++) add(0, 8'(i), 8'h00, i == 2 ? 8'h00 : 8'(8'h10 + i), 0);
        add(1, 8, 8'h77, 8'h00, 1);
        add(0, 200, 8'h00, 8'h00, 1);
        add(0, 0, 8'h00, 8'h10, 0);
        add(1, 2, 8'hFF, 8'h00, 1);
        add(0, 2, 8'h00, 8'h00, 0);

        #1;
        chk("reset_pready", pready, 0);
        chk("reset_pslverr", pslverr, 0);
        chk("reset_prdata", prdata, 0);
        @(negedge pclk); preset_n = 1'b1;
        @(posedge pclk); #1;

        foreach (vq[k]) begin
            xfer(vq[k].wr, vq[k].addr, vq[k].data, rd, er, cyc);
            chk($sformatf("vec%0d_prdata", k), rd, vq[k].exp_rd);
            chk($sformatf("vec%0d_pslverr", k), er, vq[k].exp_err);
            chk($sformatf("vec%0d_cycles", k), cyc, W + 1);
        end

        // psel & penable without a SETUP must be ignored
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'd4; pwdata = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("noset_pready", pready, 0);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        xfer(0, 4, 8'h00, rd, er, cyc);
        chk("noset_reg4", rd, 8'h14);

        // reset dropped inside the ACCESS phase of a write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd5; pwdata = 8'h3C;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk); #1;
        preset_n = 1'b0;
        #1;
        chk("rst_pready", pready, 0);
        chk("rst_pslverr", pslverr, 0);
        chk("rst_prdata", prdata, 0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk);
        @(negedge pclk); preset_n = 1'b1;
        @(posedge pclk); #1;
        xfer(0, 5, 8'h00, rd, er, cyc);
        chk("rst_reg5", rd, 8'h00);
        chk("rst_reg5_err", er, 0);
        xfer(0, 3, 8'h00, rd, er, cyc);
        chk("rst_reg3", rd, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
